mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide unit controller with HI/LO registers
//
// Purpose: sequences 32-cycle radix-2 multiply and restoring divide operations
// (plus MTHI/MTLO moves) and owns the architectural HI/LO registers.
//
// Configuration: define MDU_DIV_EN to build the divider. Without it, DIV/DIVU
// complete immediately with done and div_by_zero and leave HI/LO untouched.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   start        in   begin an operation (sampled only in IDLE)
//   op[2:0]      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//   a[31:0]      in   multiplicand / dividend / MTHI-MTLO source
//   b[31:0]      in   multiplier / divisor
//   cancel       in   flush; aborts an in-flight operation
//   busy         out  operation in flight
//   done         out  one-cycle pulse, hi/lo updated
//   div_by_zero  out  pulses with done for a divide by zero
//   hi[31:0]     out  HI register
//   lo[31:0]     out  LO register

module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;     // mul: {partial sum, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic        neg_res_q, neg_res_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
`ifdef MDU_DIV_EN
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_flag_q, dbz_flag_d;
    logic        is_div_q, is_div_d;
`endif

    // Signed ops (MULT/DIV have op[0] == 0) work on magnitudes.
    logic        is_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && a[31]) ? -a : a;
    assign b_abs     = (is_signed && b[31]) ? -b : b;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_res;
    assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, prod_q[31:1]};
    assign mul_res  = neg_res_q ? -prod_q : prod_q;

`ifdef MDU_DIV_EN
    // Restoring step: shift {rem, quo} left, try subtracting the divisor.
    // The remainder stays below the divisor, so the shifted trial fits 33 bits.
    logic [32:0] div_trial;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    assign div_trial = prod_q[63:31];
    assign div_diff  = {1'b0, div_trial} - {2'b00, opnd_q};
    assign div_next  = div_diff[33] ? {div_trial[31:0], prod_q[30:0], 1'b0}
                                    : {div_diff[31:0],  prod_q[30:0], 1'b1};
    assign quo_fix   = neg_res_q ? -prod_q[31:0]  : prod_q[31:0];
    assign rem_fix   = neg_rem_q ? -prod_q[63:32] : prod_q[63:32];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
`ifdef MDU_DIV_EN
        neg_rem_d  = neg_rem_q;
        dbz_flag_d = dbz_flag_q;
        is_div_d   = is_div_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // cancel wins over a simultaneous start
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = ST_MUL;
                            cnt_d     = 5'd0;
                            opnd_d    = a_abs;
                            prod_d    = {32'd0, b_abs};
                            neg_res_d = is_signed & (a[31] ^ b[31]);
`ifdef MDU_DIV_EN
                            is_div_d  = 1'b0;
`endif
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d    = ST_DIV;
                            cnt_d      = 5'd0;
                            opnd_d     = b_abs;
                            prod_d     = {32'd0, a_abs};
                            neg_res_d  = is_signed & (a[31] ^ b[31]);
                            neg_rem_d  = is_signed & a[31];
                            dbz_flag_d = (b == 32'd0);
                            is_div_d   = 1'b1;
                        end
`else
                        OP_DIV, OP_DIVU: begin
                            done_d = 1'b1;
                            dbz_d  = 1'b1;
                        end
`endif
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = ST_FIX;
                end
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d = div_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = ST_FIX;
                end
            end
`endif
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
`ifdef MDU_DIV_EN
                    if (is_div_q) begin
                        // Divide by zero already leaves hi = a; only lo needs forcing.
                        lo_d  = dbz_flag_q ? 32'hFFFF_FFFF : quo_fix;
                        hi_d  = rem_fix;
                        dbz_d = dbz_flag_q;
                    end else
`endif
                    begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            prod_q    <= 64'd0;
            opnd_q    <= 32'd0;
            neg_res_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MDU_DIV_EN
            neg_rem_q  <= 1'b0;
            dbz_flag_q <= 1'b0;
            is_div_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
`ifdef MDU_DIV_EN
            neg_rem_q  <= neg_rem_d;
            dbz_flag_q <= dbz_flag_d;
            is_div_q   <= is_div_d;
`endif
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];
    int   errors = 0;
    int   checks = 0;

`ifdef MDU_DIV_EN
    localparam int DIV_BUSY = 33;
`else
    localparam int DIV_BUSY = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle (or in its done cycle); returns
    // at the negedge where done is expected.
    task automatic run_op(input vec_t v, input string name);
        exp_t e;
        int   n;
        logic done_early;
        e.hi  = v.exp_hi;
        e.lo  = v.exp_lo;
        e.dbz = v.exp_dbz;
        sb.push_back(e);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        done_early = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            if (done !== 1'b0) done_early = 1'b1;
            a = $urandom;
            b = $urandom;
            n++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, 64'(n), 64'(v.exp_busy));
        chk({name, " done_while_busy"}, 64'(done_early), 64'd0);
        chk({name, " done"}, 64'(done), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, " hi"}, 64'(hi), 64'(e.hi));
            chk({name, " lo"}, 64'(lo), 64'(e.lo));
            chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
        end
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk({name, " no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // op, a, b, exp_hi, exp_lo, exp_dbz, exp_busy
        vt.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33});
        vt.push_back('{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33});
        vt.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33});
        vt.push_back('{3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 33});
        vt.push_back('{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33});
        vt.push_back('{3'd1, 32'h0000_0000, 32'h0000_3039, 32'h0000_0000, 32'h0000_0000, 1'b0, 33});
        vt.push_back('{3'd4, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0});
        vt.push_back('{3'd5, 32'hCAFE_F00D, 32'h0000_0001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0});
`ifdef MDU_DIV_EN
        vt.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
        vt.push_back('{3'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 33});
        vt.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33});
        vt.push_back('{3'd3, 32'h0000_03E8, 32'h0000_0003, 32'h0000_0001, 32'h0000_014D, 1'b0, 33});
        vt.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33});
        vt.push_back('{3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 33});
`else
        vt.push_back('{3'd2, 32'h0000_000A, 32'h0000_0002, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 0});
        vt.push_back('{3'd3, 32'h0000_0064, 32'h0000_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 0});
`endif

        // Reset held with a start pending: reset must dominate.
        rst   = 1'b0;
        start = 1'b1;
        op    = 3'd4;
        a     = 32'h1111_2222;
        repeat (3) @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));
        @(negedge clk);

        // Preload, MULT with an ignored start during busy, cancel at busy cycle 10.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op('{3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0, 1'b0, 0}, "mthi_preload");
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(negedge clk);                               // busy cycle 1
        start = 1'b0;
        chk("cancel_seq busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);                    // busy cycle 5
        start = 1'b1; op = 3'd4; a = 32'hFFFF_FFFF;
        @(negedge clk);                               // busy cycle 6
        start = 1'b0;
        chk("start_in_busy busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);                    // busy cycle 10
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        watch_no_done("cancel", 40);
        chk("cancel hi", 64'(hi), 64'h1234_5678);
        chk("cancel lo", 64'(lo), 64'd0);

        // Back-to-back ops, then cancel in the done cycle.
        run_op('{3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33}, "multu_3x4");
        run_op('{3'd5, 32'h0000_0055, 32'd0, 32'd0, 32'h0000_0055, 1'b0, 0}, "mtlo_b2b");
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_in_done hi", 64'(hi), 64'd0);
        chk("cancel_in_done lo", 64'(lo), 64'h55);

        // cancel and start together in IDLE.
        cancel = 1'b1; start = 1'b1; op = 3'd4; a = 32'h0000_0BAD;
        @(negedge clk);
        chk("cancel_start done", 64'(done), 64'd0);
        chk("cancel_start hi", 64'(hi), 64'd0);
        op = 3'd0;
        @(negedge clk);
        chk("cancel_start busy", 64'(busy), 64'd0);
        cancel = 1'b0; start = 1'b0;
        @(negedge clk);

        // Reserved ops do nothing.
        for (int r = 6; r <= 7; r++) begin
            start = 1'b1; op = 3'(r); a = 32'h1; b = 32'h1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("reserved%0d busy", r), 64'(busy), 64'd0);
            chk($sformatf("reserved%0d done", r), 64'(done), 64'd0);
            chk($sformatf("reserved%0d lo", r), 64'(lo), 64'h55);
            @(negedge clk);
        end

        // Reset at busy cycle 20, with start and cancel also asserted.
        run_op('{3'd4, 32'h0000_AAAA, 32'd0, 32'h0000_AAAA, 32'h55, 1'b0, 0}, "mthi_pre_rst");
`ifdef MDU_DIV_EN
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
`else
        start = 1'b1; op = 3'd1; a = 32'd1000; b = 32'd3;
`endif
        @(negedge clk);                               // busy cycle 1
        start = 1'b0;
        repeat (19) @(negedge clk);                   // busy cycle 20
        rst = 1'b0; start = 1'b1; op = 3'd4; a = 32'h0000_0777; cancel = 1'b1;
        @(negedge clk);
        rst = 1'b1; start = 1'b0; cancel = 1'b0;
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst div_by_zero", 64'(div_by_zero), 64'd0);
        watch_no_done("midrst", 40);
`ifdef MDU_DIV_EN
        run_op('{3'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, DIV_BUSY}, "divu_rerun");
`else
        run_op('{3'd1, 32'd1000, 32'd3, 32'd0, 32'd3000, 1'b0, 33}, "multu_rerun");
        run_op('{3'd2, 32'd10, 32'd2, 32'd0, 32'd3000, 1'b1, DIV_BUSY}, "div_disabled");
`endif
        @(negedge clk);
        chk("final done_pulse", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
